// File: rtl/spi_flash_rd.sv
// spi_flash_rd -- read-only Wishbone window onto an S25FL064P serial flash, rev 1.0
// Issues READ (0x03) and keeps ss_n low so sequential word reads skip the command phase.
`default_nettype none

module spi_flash_rd #(
  parameter int          ADR_W      = 19,
  parameter logic [23:0] FLASH_BASE = 24'h000000,
  parameter int          CLK_DIV    = 1,
  parameter int          IDLE_TO    = 64,
  parameter int          CS_GAP     = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [ADR_W:1]   wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  input  logic [1:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             ss_n,
  output logic             busy
);

  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int TW = (IDLE_TO > 2) ? $clog2(IDLE_TO) : 1;
  localparam int GW = $clog2(CS_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DATA, ACK, HOLD, GAP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] phase;
  logic [4:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [31:0]   tx;
  logic [15:0]   rx;
  logic [23:0]   cur;
  logic [23:0]   nxt;
  logic [23:0]   fa;

  logic rd_req, wr_req, in_bits, waiting, abort, bit_mid, bit_end, shift;

  logic unused_inputs;
  assign unused_inputs = ^{wb_dat_i, wb_sel_i};

  assign fa = FLASH_BASE + 24'({wb_adr_i, 1'b0});

  always_comb begin
    rd_req  = wb_stb_i & wb_cyc_i & ~wb_we_i & ~wb_ack_o;
    wr_req  = wb_stb_i & wb_cyc_i & wb_we_i & ~wb_ack_o;
    in_bits = (state == CMD) || (state == ADDR) || (state == DATA);
    waiting = (state == IDLE) || (state == HOLD) || (state == GAP);
    // Dropping the strobe mid-transfer is treated like a cycle abort so ack never meets stb=0.
    abort   = (in_bits || (state == SETUP)) && !(wb_cyc_i && wb_stb_i);
    bit_mid = in_bits && (phase == PW'(CLK_DIV - 1));
    bit_end = in_bits && (phase == PW'(2 * CLK_DIV - 1));
    state_n = state;
    case (state)
      IDLE:  if (rd_req) state_n = SETUP;
      SETUP: state_n = abort ? GAP : CMD;
      CMD:   if (abort) state_n = GAP;
             else if (bit_end && bcnt == 5'd7) state_n = ADDR;
      ADDR:  if (abort) state_n = GAP;
             else if (bit_end && bcnt == 5'd23) state_n = DATA;
      DATA:  if (abort) state_n = GAP;
             else if (bit_end && bcnt == 5'd15) state_n = ACK;
      ACK:   state_n = HOLD;
      HOLD:  if (rd_req) state_n = (fa == nxt) ? DATA : GAP;
             else if (tcnt == TW'(IDLE_TO - 2)) state_n = GAP;
      GAP:   if (gcnt == GW'(CS_GAP - 1)) state_n = rd_req ? SETUP : IDLE;
      default: state_n = IDLE;
    endcase
    shift = ((state == SETUP) && (state_n == CMD)) ||
            (bit_end && ((state_n == CMD) || (state_n == ADDR)) && (state != ADDR || state_n == ADDR));
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'h0000;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss_n     <= 1'b1;
      busy     <= 1'b0;
      phase    <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      gcnt     <= '0;
      tx       <= '0;
      rx       <= '0;
      cur      <= '0;
      nxt      <= '0;
    end else begin
      wb_ack_o <= (state_n == ACK) || (wr_req && waiting);
      ss_n     <= (state_n == IDLE) || (state_n == GAP);
      busy     <= (state_n != IDLE);
      phase    <= (in_bits && !abort && !bit_end) ? phase + 1'b1 : '0;
      tcnt     <= (state == HOLD) ? tcnt + 1'b1 : '0;
      gcnt     <= (state == GAP) ? gcnt + 1'b1 : '0;

      if (!in_bits) bcnt <= '0;
      else if (bit_end) bcnt <= (state_n == state) ? bcnt + 5'd1 : 5'd0;

      if (in_bits && !abort) begin
        if (bit_end)      sclk <= 1'b0;
        else if (bit_mid) sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
      end

      if (state_n == SETUP) begin
        tx   <= {8'h03, fa};
        mosi <= 1'b0;
      end else if (shift) begin
        mosi <= tx[31];
        tx   <= {tx[30:0], 1'b0};
      end else if (!((state_n == CMD) || (state_n == ADDR))) begin
        mosi <= 1'b0;
      end

      if ((state_n == SETUP) || ((state == HOLD) && (state_n == DATA))) cur <= fa;
      if (bit_mid && (state == DATA) && !abort) rx <= {rx[14:0], miso};

      // First byte shifted in belongs to the lower address, hence the swap.
      if (state_n == ACK) begin
        wb_dat_o <= {rx[7:0], rx[15:8]};
        nxt      <= cur + 24'd2;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_rd.sv
// tb_spi_flash_rd -- directed self-checking bench with a behavioural SPI flash model.
`default_nettype none

module tb_spi_flash_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:1] adr_d = '0;
  logic [15:0] dat_d = '0;
  logic        we_d = 1'b0;
  logic        stb_a = 1'b0, cyc_a = 1'b0, stb_b = 1'b0, cyc_b = 1'b0;
  logic        miso = 1'b0;
  logic        sel = 1'b0;

  logic [15:0] dat_a, dat_b;
  logic        ack_a, ack_b, sclk_a, sclk_b, mosi_a, mosi_b, ss_a, ss_b, busy_a, busy_b;
  logic [15:0] dat_m;
  logic        ack_m, sclk_m, mosi_m, ss_m;

  assign dat_m  = sel ? dat_b  : dat_a;
  assign ack_m  = sel ? ack_b  : ack_a;
  assign sclk_m = sel ? sclk_b : sclk_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign ss_m   = sel ? ss_b   : ss_a;

  always #5 clk = ~clk;

  spi_flash_rd u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr_d), .wb_dat_i(dat_d), .wb_dat_o(dat_a),
    .wb_sel_i(2'b11), .wb_we_i(we_d), .wb_stb_i(stb_a), .wb_cyc_i(cyc_a), .wb_ack_o(ack_a),
    .sclk(sclk_a), .mosi(mosi_a), .miso(miso), .ss_n(ss_a), .busy(busy_a)
  );

  spi_flash_rd #(.FLASH_BASE(24'hFFFFFE)) u_dut_wrap (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr_d), .wb_dat_i(dat_d), .wb_dat_o(dat_b),
    .wb_sel_i(2'b11), .wb_we_i(we_d), .wb_stb_i(stb_b), .wb_cyc_i(cyc_b), .wb_ack_o(ack_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(miso), .ss_n(ss_b), .busy(busy_b)
  );

  // Flash contents: four fixed bytes at the bottom, a simple hash elsewhere.
  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'd0:   return 8'h34;
      24'd1:   return 8'h12;
      24'd2:   return 8'hCD;
      24'd3:   return 8'hAB;
      default: return a[7:0] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  logic [31:0] fl_sh = '0;
  logic [7:0]  fl_cmd = '0;
  logic [23:0] fl_addr = '0, fl_oaddr = '0;
  logic [7:0]  fl_b;
  int fl_cnt = 0, fl_opos = 0, fl_ncmd = 0, pulses = 0;

  always @(negedge ss_m) begin
    fl_cnt  = 0;
    fl_opos = 0;
  end

  always @(posedge sclk_m) begin
    pulses++;
    if (!ss_m && fl_cnt < 32) begin
      fl_sh = {fl_sh[30:0], mosi_m};
      fl_cnt++;
      if (fl_cnt == 32) begin
        fl_cmd   = fl_sh[31:24];
        fl_addr  = fl_sh[23:0];
        fl_oaddr = fl_sh[23:0];
        fl_ncmd++;
      end
    end
  end

  always @(negedge sclk_m) begin
    if (!ss_m && fl_cnt == 32) begin
      fl_b = fbyte(fl_oaddr);
      miso = fl_b[7 - fl_opos];
      if (fl_opos == 7) begin
        fl_opos  = 0;
        fl_oaddr = fl_oaddr + 24'd1;
      end else begin
        fl_opos++;
      end
    end
  end

  int passed = 0, total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [19:1] adr, input logic we);
    adr_d = adr;
    we_d  = we;
    if (sel) begin stb_b = 1'b1; cyc_b = 1'b1; end
    else     begin stb_a = 1'b1; cyc_a = 1'b1; end
  endtask

  task automatic release_bus();
    stb_a = 1'b0; cyc_a = 1'b0; stb_b = 1'b0; cyc_b = 1'b0; we_d = 1'b0;
  endtask

  task automatic wb_xfer(input logic [19:1] adr, input logic we, output logic [15:0] dat,
                         output int lat, output int sshi);
    drive_req(adr, we);
    lat  = 0;
    sshi = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (ss_m) sshi++;
    end while (!ack_m && lat < 400);
    dat = dat_m;
    release_bus();
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'd0, ack_m}, 32'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_a && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idle", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    int lat, sshi, n0, p0, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ack",  {31'd0, ack_a}, 32'd0);
    chk("rst_dat",  {16'd0, dat_a}, 32'd0);
    chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_mosi", {31'd0, mosi_a}, 32'd0);
    chk("rst_ss",   {31'd0, ss_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);

    // Fresh read at word 0
    p0 = pulses;
    wb_xfer(19'd0, 1'b0, d, lat, sshi);
    chk("t1_lat",    lat, 98);
    chk("t1_dat",    {16'd0, d}, 32'h1234);
    chk("t1_cmd",    {24'd0, fl_cmd}, 32'h03);
    chk("t1_addr",   {8'd0, fl_addr}, 32'h000000);
    chk("t1_pulses", pulses - p0, 48);
    chk("t1_ss_low", {31'd0, ss_a}, 32'd0);

    // Sequential continuation
    n0 = fl_ncmd; p0 = pulses;
    wb_xfer(19'd1, 1'b0, d, lat, sshi);
    chk("t2_lat",    lat, 33);
    chk("t2_dat",    {16'd0, d}, 32'hABCD);
    chk("t2_nocmd",  fl_ncmd - n0, 0);
    chk("t2_pulses", pulses - p0, 16);

    // Non-sequential from HOLD: gap then fresh command
    n0 = fl_ncmd;
    wb_xfer(19'h100, 1'b0, d, lat, sshi);
    chk("t3_lat",    lat, 100);
    chk("t3_gap",    {31'd0, sshi >= 2}, 32'd1);
    chk("t3_cmd",    fl_ncmd - n0, 1);
    chk("t3_addr",   {8'd0, fl_addr}, 32'h000200);
    chk("t3_dat",    {16'd0, d}, 32'h5B5A);

    // Idle timeout after a read
    wb_xfer(19'd0, 1'b0, d, lat, sshi);
    chk("t4_lat", lat, 100);
    chk("t4_dat", {16'd0, d}, 32'h1234);
    n = 1;
    while (!ss_a && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t4_timeout", n, 64);
    wait_idle();
    n0 = fl_ncmd;
    wb_xfer(19'd1, 1'b0, d, lat, sshi);
    chk("t4_fresh_lat",  lat, 98);
    chk("t4_fresh_cmd",  fl_ncmd - n0, 1);
    chk("t4_fresh_addr", {8'd0, fl_addr}, 32'h000002);
    chk("t4_fresh_dat",  {16'd0, d}, 32'hABCD);

    // Write is acked without SPI traffic; sequential read still continues
    dat_d = 16'hFFFF;
    p0 = pulses; n0 = fl_ncmd;
    wb_xfer(19'd5, 1'b1, d, lat, sshi);
    chk("t5_wr_lat",    lat, 1);
    chk("t5_wr_pulses", pulses - p0, 0);
    chk("t5_wr_ss",     {31'd0, ss_a}, 32'd0);
    wb_xfer(19'd2, 1'b0, d, lat, sshi);
    chk("t5_seq_lat",   lat, 33);
    chk("t5_seq_nocmd", fl_ncmd - n0, 0);
    chk("t5_seq_dat",   {16'd0, d}, 32'h5F5E);

    // Reset in the middle of a fresh read
    wait_idle();
    drive_req(19'd0, 1'b0);
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_ss",   {31'd0, ss_a}, 32'd1);
    chk("t6_rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("t6_rst_ack",  {31'd0, ack_a}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("t6_rst_dat",  {16'd0, dat_a}, 32'd0);
    rst = 1'b0;
    release_bus();
    @(posedge clk); #1;

    // Master abort in the middle of a fresh read
    drive_req(19'd0, 1'b0);
    repeat (40) @(posedge clk);
    #1 release_bus();
    @(posedge clk); #1;
    chk("t6_ab_ss",   {31'd0, ss_a}, 32'd1);
    chk("t6_ab_sclk", {31'd0, sclk_a}, 32'd0);
    chk("t6_ab_ack",  {31'd0, ack_a}, 32'd0);
    chk("t6_ab_gap",  {31'd0, busy_a}, 32'd1);
    repeat (2) @(posedge clk);
    #1 chk("t6_ab_idle", {31'd0, busy_a}, 32'd0);
    n0 = fl_ncmd;
    wb_xfer(19'd1, 1'b0, d, lat, sshi);
    chk("t6_after_lat", lat, 98);
    chk("t6_after_cmd", fl_ncmd - n0, 1);
    chk("t6_after_dat", {16'd0, d}, 32'hABCD);

    // FLASH_BASE near the top of flash: continuation across the 24-bit wrap
    sel = 1'b1;
    @(posedge clk); #1;
    wb_xfer(19'd0, 1'b0, d, lat, sshi);
    chk("t7_lat",  lat, 98);
    chk("t7_addr", {8'd0, fl_addr}, 32'hFFFFFE);
    chk("t7_dat",  {16'd0, d}, 32'h5A5B);
    n0 = fl_ncmd;
    wb_xfer(19'd1, 1'b0, d, lat, sshi);
    chk("t7_wrap_lat",   lat, 33);
    chk("t7_wrap_nocmd", fl_ncmd - n0, 0);
    chk("t7_wrap_dat",   {16'd0, d}, 32'h1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
